axi4_lite_sfp_mc: RTL and testbench
===================================

# axi4_lite_sfp_mc

Parametrised multi-channel AXI4-Lite register bank for the SFP link controller, replacing the single-station SFP register block. Sits between the PS AXI interconnect and the SFP master/slave protocol engines. Exposes master command/response, slave command/response, per-station status words for `C_CH_NUM` stations, sticky event flags with interrupt, write-to-pulse strobes, coherent 64-bit response reads and SLVERR decoding.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width; only 32 supported.
- `C_CH_NUM`, 4: remote stations reported (1..8).
- `C_CH_REG_NUM`, 9: status words per station (1..16).
- `C_ID_W`, `max(1,$clog2(C_CH_NUM))`: station ID width.
- `C_S_AXI_ADDR_WIDTH`, `$clog2(16 + C_CH_NUM*C_CH_REG_NUM) + 2`: byte address width.
- `S_AXI_ACLK  in  1  single clock`
- `S_AXI_ARESETN  in  1  asynchronous, active-low reset`
- `S_AXI_*  AXI4-Lite slave channels (AW/W/B/AR/R)  standard widths; AWPROT/ARPROT ignored`
- `o_sfp_en  out  1  CTRL[0]`
- `o_sfp_id  out  C_ID_W  ID register`
- `o_m_sfp_cmd, o_m_sfp_data  out  32 each  master command/data`
- `o_m_sfp_flag  out  1  one-cycle start pulse`
- `i_m_sfp_rsp  in  64`; `i_m_sfp_rsp_valid  in  1  one-cycle response capture strobe`
- `i_s_sfp_cmd, i_s_sfp_data  in  32 each`; `i_s_sfp_valid  in  1  one-cycle capture strobe`
- `o_s_sfp_rsp  out  64  slave response`; `o_s_sfp_rsp_flag  out  1  one-cycle pulse`
- `i_ch_status  in  C_CH_NUM*C_CH_REG_NUM*32  flattened station status, word k of station c at [(c*C_CH_REG_NUM+k)*32 +: 32]`
- `o_irq  out  1  level interrupt`

## Operation
- Word map (byte offset): 0x00 CTRL RW [0]=en [1]=freeze; 0x04 ID RW; 0x08 M_CMD RW; 0x0C M_DATA RW; 0x10 M_GO W1P; 0x14 S_RSP_LO RW; 0x18 S_RSP_HI RW; 0x1C S_RSP_GO W1P; 0x20 M_RSP_LO RO; 0x24 M_RSP_HI RO; 0x28 S_CMD RO; 0x2C S_DATA RO; 0x30 STATUS RW1C; 0x34 IRQ_EN RW [3:0]; 0x38–0x3C reserved; 0x40 + 4*(c*C_CH_REG_NUM+k) station status RO.
- RW registers honour WSTRB per byte; unimplemented bits read 0.
- W1P: write with WSTRB[0] and WDATA[0]=1 produces one pulse; register reads 0. S_RSP_GO copies S_RSP_HI:LO to `o_s_sfp_rsp` on the pulse cycle.
- M_RSP/S_CMD/S_DATA load only on their valid strobes.
- STATUS: [0] m_rsp_new, [1] s_cmd_new set by the respective strobe; [2] m_overrun, [3] s_overrun set when strobe arrives while [0]/[1] already set. W1C via byte 0. Set wins over simultaneous clear.
- `o_irq = |(STATUS[3:0] & IRQ_EN[3:0])`, registered.
- Reading M_RSP_LO copies M_RSP_HI into a shadow; M_RSP_HI reads return the shadow (coherent pair even if a strobe lands between reads).
- Station status sampled every cycle while CTRL[1]=0; held while 1.
- Writes to RO, reserved or out-of-range addresses: no effect, BRESP=SLVERR (2'b10). Reads of reserved/out-of-range: RDATA=0, RRESP=SLVERR. All else OKAY.

## Timing
- Reset: all AXI ready/valid 0, RDATA 0, all registers/outputs 0, shadow 0, `o_irq` 0.
- Write: AWREADY and WREADY pulse together one cycle after both AWVALID and WVALID high with no B pending; register update on that same edge; BVALID next cycle, held until BREADY. One write outstanding.
- Read: ARREADY pulses one cycle after ARVALID with no R pending; RDATA/RRESP/RVALID next cycle, held until RREADY. One read outstanding; read and write proceed concurrently.
- Read returns register value before the capture edge of a same-cycle strobe.
- `o_m_sfp_flag`/`o_s_sfp_rsp_flag`: high exactly one cycle, the cycle after the write accept edge. `o_m_sfp_cmd/data`, `o_sfp_en/id`: update one cycle after accept.
- STATUS set visible one cycle after strobe; `o_irq` one cycle later.
- Reset asserted mid-transaction: transaction dropped, all outputs to reset values immediately.

## Structure
- Package `axi4_lite_sfp_pkg`: word offsets, STATUS bit indices, RESP_OKAY/RESP_SLVERR, base of station window (0x40).
- Sub-module `axi4_lite_sfp_slv_if`: AXI handshake front-end giving `wr_en/wr_addr/wr_data/wr_strb/wr_resp` and `rd_en/rd_addr/rd_data/rd_resp`; top holds decode and registers.

## Test plan
- Write 0xA5 to 0x08, 1 to 0x10 → `o_m_sfp_cmd`=0xA5, single-cycle `o_m_sfp_flag`; read 0x10 → 0.
- Pulse `i_m_sfp_rsp_valid` with 0x11112222_33334444, read 0x20, pulse new rsp 0x5555…, read 0x24 → 0x11112222; STATUS=0x5 (overrun); IRQ_EN=4 → `o_irq`=1; write 4 to 0x30 → `o_irq`=0.
- Strobe and W1C of bit 1 in same cycle → STATUS[1] stays 1.
- C_CH_NUM=4: drive station 3 word 8 = 0xDEADBEEF, read 0x40+4*35 → 0xDEADBEEF; set freeze, change input, reread → unchanged.
- Write 0x20 → BRESP=2'b10, no change; read 0x38 → RDATA=0, RRESP=2'b10.
- WSTRB=4'b0010 write 0xFFFFFFFF to 0x0C (was 0) → 0x0000FF00; BREADY held low 5 cycles → BVALID held, no second AWREADY.

Source files
------------

// File: rtl/axi4_lite_sfp_pkg.sv
// Shared constants for the multi-channel SFP AXI4-Lite register bank.
// Holds the register word indices, the STATUS bit positions, the AXI response codes and the station window base.
// Holds a helper that expands a byte-lane strobe into a bit mask. There are no ports.
package axi4_lite_sfp_pkg;

   // Register word indices (byte offset >> 2)
   localparam logic [31:0] W_CTRL      = 32'd0;   // 0x00
   localparam logic [31:0] W_ID        = 32'd1;   // 0x04
   localparam logic [31:0] W_M_CMD     = 32'd2;   // 0x08
   localparam logic [31:0] W_M_DATA    = 32'd3;   // 0x0C
   localparam logic [31:0] W_M_GO      = 32'd4;   // 0x10
   localparam logic [31:0] W_S_RSP_LO  = 32'd5;   // 0x14
   localparam logic [31:0] W_S_RSP_HI  = 32'd6;   // 0x18
   localparam logic [31:0] W_S_RSP_GO  = 32'd7;   // 0x1C
   localparam logic [31:0] W_M_RSP_LO  = 32'd8;   // 0x20
   localparam logic [31:0] W_M_RSP_HI  = 32'd9;   // 0x24
   localparam logic [31:0] W_S_CMD     = 32'd10;  // 0x28
   localparam logic [31:0] W_S_DATA    = 32'd11;  // 0x2C
   localparam logic [31:0] W_STATUS    = 32'd12;  // 0x30
   localparam logic [31:0] W_IRQ_EN    = 32'd13;  // 0x34

   // Per-station status words start right after the 16-word control block
   localparam logic [31:0] ST_BASE_BYTE = 32'h40;
   localparam logic [31:0] ST_BASE_W    = ST_BASE_BYTE >> 2;

   // STATUS bit positions
   localparam int ST_M_RSP_NEW = 0;
   localparam int ST_S_CMD_NEW = 1;
   localparam int ST_M_OVR     = 2;
   localparam int ST_S_OVR     = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axi4_lite_sfp_mc_if.sv
// AXI4-Lite slave bundle for the SFP register bank.
// The slave modport is used by the register bank and the master modport by whatever drives it.
// Ports: AW/W/B/AR/R channels with ADDR_W address and DATA_W data; clock and reset travel separately.
interface axi4_lite_sfp_mc_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_sfp_slv_if.sv
// AXI4-Lite handshake front-end: turns the bus into one-cycle wr_en/rd_en register strobes.
// Latency: AW/W ready one cycle after both valids, B one cycle after accept; AR ready one cycle after valid, R one cycle after accept.
// Backpressure: one write and one read outstanding; a held B or R blocks the next accept on that side.
// Ports: clk/rst_n, s_axi slave modport, wr_* outputs with wr_resp back from decode, rd_* outputs with rd_data/rd_resp back.
module axi4_lite_sfp_slv_if #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   axi4_lite_sfp_mc_if.slave s_axi,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [DW-1:0]    wr_data,
   output logic [DW/8-1:0]  wr_strb,
   input  logic [1:0]       wr_resp,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [DW-1:0]    rd_data,
   input  logic [1:0]       rd_resp
);

   logic          aw_rdy_q, aw_rdy_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q,  bresp_d;
   logic          ar_rdy_q, ar_rdy_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rresp_q,  rresp_d;
   logic [DW-1:0] rdata_q,  rdata_d;

   logic unused_prot;
   assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

   // Address and data are taken straight from the bus on the accept edge
   assign wr_en   = aw_rdy_q & s_axi.awvalid & s_axi.wvalid;
   assign wr_addr = s_axi.awaddr;
   assign wr_data = s_axi.wdata;
   assign wr_strb = s_axi.wstrb;
   assign rd_en   = ar_rdy_q & s_axi.arvalid;
   assign rd_addr = s_axi.araddr;

   always_comb begin
      aw_rdy_d = 1'b0;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      ar_rdy_d = 1'b0;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;

      // Ready is a single-cycle pulse; never re-armed while a response is pending
      if (s_axi.awvalid && s_axi.wvalid && !bvalid_q && !aw_rdy_q) begin
         aw_rdy_d = 1'b1;
      end
      if (wr_en) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_resp;
      end else if (bvalid_q && s_axi.bready) begin
         bvalid_d = 1'b0;
      end

      if (s_axi.arvalid && !rvalid_q && !ar_rdy_q) begin
         ar_rdy_d = 1'b1;
      end
      if (rd_en) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_resp;
         rdata_d  = rd_data;
      end else if (rvalid_q && s_axi.rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_rdy_q <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
         ar_rdy_q <= 1'b0;
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= '0;
      end else begin
         aw_rdy_q <= aw_rdy_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         ar_rdy_q <= ar_rdy_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_axi.awready = aw_rdy_q;
   assign s_axi.wready  = aw_rdy_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = ar_rdy_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

endmodule

// File: rtl/axi4_lite_sfp_mc.sv
// Multi-channel SFP link-controller register bank: master/slave command and response, station status, sticky events, IRQ.
// Latency: register writes land on the AXI accept edge, so outputs and pulses appear the cycle after; reads are sampled on the AR accept edge.
// Backpressure: the AXI front-end holds B/R until ready and accepts nothing new on that side meanwhile.
// Ports: S_AXI_ACLK/S_AXI_ARESETN, s_axi slave bundle, o_sfp_en/id, master cmd/data/flag and rsp in,
// slave cmd/data in and rsp/flag out, flattened i_ch_status, o_irq.
module axi4_lite_sfp_mc
   import axi4_lite_sfp_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_CH_NUM           = 4,
   parameter int C_CH_REG_NUM       = 9,
   parameter int C_ID_W             = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1,
   parameter int C_S_AXI_ADDR_WIDTH = $clog2(16 + C_CH_NUM*C_CH_REG_NUM) + 2
) (
   input  logic                                 S_AXI_ACLK,
   input  logic                                 S_AXI_ARESETN,
   axi4_lite_sfp_mc_if.slave                    s_axi,
   output logic                                 o_sfp_en,
   output logic [C_ID_W-1:0]                    o_sfp_id,
   output logic [31:0]                          o_m_sfp_cmd,
   output logic [31:0]                          o_m_sfp_data,
   output logic                                 o_m_sfp_flag,
   input  logic [63:0]                          i_m_sfp_rsp,
   input  logic                                 i_m_sfp_rsp_valid,
   input  logic [31:0]                          i_s_sfp_cmd,
   input  logic [31:0]                          i_s_sfp_data,
   input  logic                                 i_s_sfp_valid,
   output logic [63:0]                          o_s_sfp_rsp,
   output logic                                 o_s_sfp_rsp_flag,
   input  logic [C_CH_NUM*C_CH_REG_NUM*32-1:0]  i_ch_status,
   output logic                                 o_irq
);

   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int ST_WORDS = C_CH_NUM * C_CH_REG_NUM;

   logic            wr_en, rd_en;
   logic [AW-1:0]   wr_addr, rd_addr;
   logic [DW-1:0]   wr_data, rd_data;
   logic [DW/8-1:0] wr_strb;
   logic [1:0]      wr_resp, rd_resp;

   axi4_lite_sfp_slv_if #(.AW(AW), .DW(DW)) u_slv_if (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .s_axi   (s_axi),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_resp (wr_resp),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_resp (rd_resp)
   );

   logic [1:0]          ctrl_q,      ctrl_d;
   logic [C_ID_W-1:0]   id_q,        id_d;
   logic [31:0]         m_cmd_q,     m_cmd_d;
   logic [31:0]         m_data_q,    m_data_d;
   logic                m_flag_q,    m_flag_d;
   logic [31:0]         s_rsp_lo_q,  s_rsp_lo_d;
   logic [31:0]         s_rsp_hi_q,  s_rsp_hi_d;
   logic [63:0]         s_rsp_q,     s_rsp_d;
   logic                s_flag_q,    s_flag_d;
   logic [63:0]         m_rsp_q,     m_rsp_d;
   logic [31:0]         m_rsp_shd_q, m_rsp_shd_d;
   logic [31:0]         s_cmd_q,     s_cmd_d;
   logic [31:0]         s_data_q,    s_data_d;
   logic [3:0]          status_q,    status_d;
   logic [3:0]          irq_en_q,    irq_en_d;
   logic                irq_q,       irq_d;
   logic [ST_WORDS*32-1:0] st_q,     st_d;

   logic [31:0] wr_idx, rd_idx, wr_mask;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

   assign wr_idx  = 32'(wr_addr[AW-1:2]);
   assign rd_idx  = 32'(rd_addr[AW-1:2]);
   assign wr_mask = strb_to_mask(wr_strb);

   // Write response: only the writable control words answer OKAY
   always_comb begin
      wr_resp = RESP_SLVERR;
      case (wr_idx)
         W_CTRL, W_ID, W_M_CMD, W_M_DATA, W_M_GO, W_S_RSP_LO,
         W_S_RSP_HI, W_S_RSP_GO, W_STATUS, W_IRQ_EN: wr_resp = RESP_OKAY;
         default: wr_resp = RESP_SLVERR;
      endcase
   end

   // Read mux works on pre-edge register values, so a strobe landing on the
   // accept edge is not seen by this read
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (rd_idx)
         W_CTRL:     rd_data = 32'(ctrl_q);
         W_ID:       rd_data = 32'(id_q);
         W_M_CMD:    rd_data = m_cmd_q;
         W_M_DATA:   rd_data = m_data_q;
         W_M_GO, W_S_RSP_GO: rd_data = '0;
         W_S_RSP_LO: rd_data = s_rsp_lo_q;
         W_S_RSP_HI: rd_data = s_rsp_hi_q;
         W_M_RSP_LO: rd_data = m_rsp_q[31:0];
         W_M_RSP_HI: rd_data = m_rsp_shd_q;
         W_S_CMD:    rd_data = s_cmd_q;
         W_S_DATA:   rd_data = s_data_q;
         W_STATUS:   rd_data = 32'(status_q);
         W_IRQ_EN:   rd_data = 32'(irq_en_q);
         default: begin
            rd_resp = RESP_SLVERR;
            for (int k = 0; k < ST_WORDS; k++) begin
               if (rd_idx == ST_BASE_W + 32'(k)) begin
                  rd_data = st_q[k*32 +: 32];
                  rd_resp = RESP_OKAY;
               end
            end
         end
      endcase
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      id_d        = id_q;
      m_cmd_d     = m_cmd_q;
      m_data_d    = m_data_q;
      m_flag_d    = 1'b0;
      s_rsp_lo_d  = s_rsp_lo_q;
      s_rsp_hi_d  = s_rsp_hi_q;
      s_rsp_d     = s_rsp_q;
      s_flag_d    = 1'b0;
      m_rsp_d     = m_rsp_q;
      m_rsp_shd_d = m_rsp_shd_q;
      s_cmd_d     = s_cmd_q;
      s_data_d    = s_data_q;
      status_d    = status_q;
      irq_en_d    = irq_en_q;

      if (wr_en) begin
         case (wr_idx)
            W_CTRL:     ctrl_d     = (ctrl_q & ~wr_mask[1:0]) | (wr_data[1:0] & wr_mask[1:0]);
            W_ID:       id_d       = (id_q & ~wr_mask[C_ID_W-1:0]) | (wr_data[C_ID_W-1:0] & wr_mask[C_ID_W-1:0]);
            W_M_CMD:    m_cmd_d    = (m_cmd_q & ~wr_mask) | (wr_data & wr_mask);
            W_M_DATA:   m_data_d   = (m_data_q & ~wr_mask) | (wr_data & wr_mask);
            W_M_GO:     m_flag_d   = wr_strb[0] & wr_data[0];
            W_S_RSP_LO: s_rsp_lo_d = (s_rsp_lo_q & ~wr_mask) | (wr_data & wr_mask);
            W_S_RSP_HI: s_rsp_hi_d = (s_rsp_hi_q & ~wr_mask) | (wr_data & wr_mask);
            W_S_RSP_GO: begin
               if (wr_strb[0] && wr_data[0]) begin
                  s_flag_d = 1'b1;
                  s_rsp_d  = {s_rsp_hi_q, s_rsp_lo_q};
               end
            end
            W_STATUS:   if (wr_strb[0]) status_d = status_q & ~wr_data[3:0];
            W_IRQ_EN:   irq_en_d   = (irq_en_q & ~wr_mask[3:0]) | (wr_data[3:0] & wr_mask[3:0]);
            default: ;
         endcase
      end

      // Sticky event bits are applied after the W1C so a same-cycle set wins;
      // overrun looks at the pre-clear state
      if (i_m_sfp_rsp_valid) begin
         m_rsp_d                = i_m_sfp_rsp;
         status_d[ST_M_RSP_NEW] = 1'b1;
         if (status_q[ST_M_RSP_NEW]) status_d[ST_M_OVR] = 1'b1;
      end
      if (i_s_sfp_valid) begin
         s_cmd_d                = i_s_sfp_cmd;
         s_data_d               = i_s_sfp_data;
         status_d[ST_S_CMD_NEW] = 1'b1;
         if (status_q[ST_S_CMD_NEW]) status_d[ST_S_OVR] = 1'b1;
      end

      // Latch the high half when the low half is read so the pair is coherent
      if (rd_en && rd_idx == W_M_RSP_LO) begin
         m_rsp_shd_d = m_rsp_q[63:32];
      end
   end

   assign irq_d = |(status_q & irq_en_q);
   assign st_d  = ctrl_q[1] ? st_q : i_ch_status;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ctrl_q      <= '0;
         id_q        <= '0;
         m_cmd_q     <= '0;
         m_data_q    <= '0;
         m_flag_q    <= 1'b0;
         s_rsp_lo_q  <= '0;
         s_rsp_hi_q  <= '0;
         s_rsp_q     <= '0;
         s_flag_q    <= 1'b0;
         m_rsp_q     <= '0;
         m_rsp_shd_q <= '0;
         s_cmd_q     <= '0;
         s_data_q    <= '0;
         status_q    <= '0;
         irq_en_q    <= '0;
         irq_q       <= 1'b0;
         st_q        <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         id_q        <= id_d;
         m_cmd_q     <= m_cmd_d;
         m_data_q    <= m_data_d;
         m_flag_q    <= m_flag_d;
         s_rsp_lo_q  <= s_rsp_lo_d;
         s_rsp_hi_q  <= s_rsp_hi_d;
         s_rsp_q     <= s_rsp_d;
         s_flag_q    <= s_flag_d;
         m_rsp_q     <= m_rsp_d;
         m_rsp_shd_q <= m_rsp_shd_d;
         s_cmd_q     <= s_cmd_d;
         s_data_q    <= s_data_d;
         status_q    <= status_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
         st_q        <= st_d;
      end
   end

   assign o_sfp_en         = ctrl_q[0];
   assign o_sfp_id         = id_q;
   assign o_m_sfp_cmd      = m_cmd_q;
   assign o_m_sfp_data     = m_data_q;
   assign o_m_sfp_flag     = m_flag_q;
   assign o_s_sfp_rsp      = s_rsp_q;
   assign o_s_sfp_rsp_flag = s_flag_q;
   assign o_irq            = irq_q;

endmodule

// File: tb/tb_axi4_lite_sfp_mc.sv
module tb_axi4_lite_sfp_mc;

   localparam int CH  = 4;
   localparam int REG = 9;
   localparam int AW  = 8;
   localparam int IDW = 2;

   logic clk;
   logic rst_n;

   logic [IDW-1:0]         o_sfp_id;
   logic                   o_sfp_en, o_m_sfp_flag, o_s_sfp_rsp_flag, o_irq;
   logic [31:0]            o_m_sfp_cmd, o_m_sfp_data;
   logic [63:0]            i_m_sfp_rsp, o_s_sfp_rsp;
   logic                   i_m_sfp_rsp_valid, i_s_sfp_valid;
   logic [31:0]            i_s_sfp_cmd, i_s_sfp_data;
   logic [CH*REG*32-1:0]   ch_status;

   axi4_lite_sfp_mc_if #(.ADDR_W(AW), .DATA_W(32)) axi ();

   axi4_lite_sfp_mc #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_CH_NUM           (CH),
      .C_CH_REG_NUM       (REG)
   ) dut (
      .S_AXI_ACLK        (clk),
      .S_AXI_ARESETN     (rst_n),
      .s_axi             (axi),
      .o_sfp_en          (o_sfp_en),
      .o_sfp_id          (o_sfp_id),
      .o_m_sfp_cmd       (o_m_sfp_cmd),
      .o_m_sfp_data      (o_m_sfp_data),
      .o_m_sfp_flag      (o_m_sfp_flag),
      .i_m_sfp_rsp       (i_m_sfp_rsp),
      .i_m_sfp_rsp_valid (i_m_sfp_rsp_valid),
      .i_s_sfp_cmd       (i_s_sfp_cmd),
      .i_s_sfp_data      (i_s_sfp_data),
      .i_s_sfp_valid     (i_s_sfp_valid),
      .o_s_sfp_rsp       (o_s_sfp_rsp),
      .o_s_sfp_rsp_flag  (o_s_sfp_rsp_flag),
      .i_ch_status       (ch_status),
      .o_irq             (o_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_flag_cnt = 0;
   int s_flag_cnt = 0;

   // Scoreboard queues: expected responses pushed at issue time
   string       bq_name[$];
   logic [1:0]  bq_resp[$];
   string       rq_name[$];
   logic [31:0] rq_data[$];
   logic [1:0]  rq_resp[$];

   string       mon_b_name, mon_r_name;
   logic [1:0]  mon_b_resp, mon_r_resp;
   logic [31:0] mon_r_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // B channel monitor
   always @(negedge clk) begin
      if (axi.bvalid && axi.bready) begin
         checks++;
         if (bq_resp.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected: got bresp %0b with nothing expected", axi.bresp);
         end else begin
            mon_b_name = bq_name.pop_front();
            mon_b_resp = bq_resp.pop_front();
            if (axi.bresp !== mon_b_resp) begin
               errors++;
               $display("FAIL %s_bresp: got %0b expected %0b", mon_b_name, axi.bresp, mon_b_resp);
            end
         end
      end
   end

   // R channel monitor
   always @(negedge clk) begin
      if (axi.rvalid && axi.rready) begin
         checks++;
         if (rq_data.size() == 0) begin
            errors++;
            $display("FAIL r_unexpected: got rdata 0x%0h with nothing expected", axi.rdata);
         end else begin
            mon_r_name = rq_name.pop_front();
            mon_r_data = rq_data.pop_front();
            mon_r_resp = rq_resp.pop_front();
            if (axi.rdata !== mon_r_data) begin
               errors++;
               $display("FAIL %s_rdata: got 0x%0h expected 0x%0h", mon_r_name, axi.rdata, mon_r_data);
            end
            checks++;
            if (axi.rresp !== mon_r_resp) begin
               errors++;
               $display("FAIL %s_rresp: got %0b expected %0b", mon_r_name, axi.rresp, mon_r_resp);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (o_m_sfp_flag)     m_flag_cnt++;
      if (o_s_sfp_rsp_flag) s_flag_cnt++;
   end

   task automatic axi_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input bit fire_s);
      bit ok;
      bq_name.push_back(name);
      bq_resp.push_back(exp_resp);
      axi.awaddr  = addr;
      axi.wdata   = data;
      axi.wstrb   = strb;
      axi.awvalid = 1'b1;
      axi.wvalid  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (axi.awready && axi.wready) ok = 1'b1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_awready_timeout: got no awready, required within 20 cycles", name);
         axi.awvalid = 1'b0;
         axi.wvalid  = 1'b0;
         return;
      end
      if (fire_s) i_s_sfp_valid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid   = 1'b0;
      axi.wvalid    = 1'b0;
      i_s_sfp_valid = 1'b0;
      for (int i = 0; i < 20 && !axi.bvalid; i++) begin
         @(posedge clk); #1;
      end
      if (!axi.bvalid) begin
         checks++; errors++;
         $display("FAIL %s_bvalid_timeout: got no bvalid, required within 20 cycles", name);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic axi_read(input string name, input logic [7:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit ok;
      rq_name.push_back(name);
      rq_data.push_back(exp_data);
      rq_resp.push_back(exp_resp);
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (axi.arready) ok = 1'b1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_arready_timeout: got no arready, required within 20 cycles", name);
         axi.arvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      for (int i = 0; i < 20 && !axi.rvalid; i++) begin
         @(posedge clk); #1;
      end
      if (!axi.rvalid) begin
         checks++; errors++;
         $display("FAIL %s_rvalid_timeout: got no rvalid, required within 20 cycles", name);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_m(input logic [63:0] rsp);
      i_m_sfp_rsp       = rsp;
      i_m_sfp_rsp_valid = 1'b1;
      @(posedge clk); #1;
      i_m_sfp_rsp_valid = 1'b0;
   endtask

   task automatic pulse_s(input logic [31:0] cmd, input logic [31:0] data);
      i_s_sfp_cmd   = cmd;
      i_s_sfp_data  = data;
      i_s_sfp_valid = 1'b1;
      @(posedge clk); #1;
      i_s_sfp_valid = 1'b0;
   endtask

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst_n = 1'b0;
      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
      axi.bready = 1'b1;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b1;
      i_m_sfp_rsp = '0; i_m_sfp_rsp_valid = 1'b0;
      i_s_sfp_cmd = '0; i_s_sfp_data = '0; i_s_sfp_valid = 1'b0;
      ch_status = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_handshake", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}, 0);
      check("reset_rdata", axi.rdata, 0);
      check("reset_outputs", {o_irq, o_m_sfp_flag, o_s_sfp_rsp_flag, o_sfp_en, o_sfp_id}, 0);
      check("reset_m_cmd", o_m_sfp_cmd, 0);
      check("reset_s_rsp", o_s_sfp_rsp, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Master command and start pulse
      axi_write("w_m_cmd", 8'h08, 32'h0000_00A5, 4'hF, OK, 1'b0);
      check("m_cmd_out", o_m_sfp_cmd, 32'hA5);
      check("m_flag_before_go", m_flag_cnt, 0);
      axi_write("w_m_go", 8'h10, 32'h1, 4'hF, OK, 1'b0);
      check("m_flag_one_pulse", m_flag_cnt, 1);
      axi_write("w_m_go_bit0_clear", 8'h10, 32'h2, 4'hF, OK, 1'b0);
      check("m_flag_no_pulse", m_flag_cnt, 1);
      axi_read("r_m_go", 8'h10, 32'h0, OK);
      axi_read("r_m_cmd", 8'h08, 32'hA5, OK);
      axi_write("w_ctrl", 8'h00, 32'h1, 4'hF, OK, 1'b0);
      axi_write("w_id", 8'h04, 32'hFF, 4'hF, OK, 1'b0);
      check("sfp_en", o_sfp_en, 1);
      check("sfp_id", o_sfp_id, 3);
      axi_read("r_id_masked", 8'h04, 32'h3, OK);

      // Master response capture, coherent hi read, overrun, IRQ
      pulse_m(64'h1111_2222_3333_4444);
      axi_read("r_m_rsp_lo", 8'h20, 32'h3333_4444, OK);
      pulse_m(64'h5555_6666_7777_8888);
      axi_read("r_m_rsp_hi_shadow", 8'h24, 32'h1111_2222, OK);
      axi_read("r_status_ovr", 8'h30, 32'h5, OK);
      check("irq_before_en", o_irq, 0);
      axi_write("w_irq_en", 8'h34, 32'h4, 4'hF, OK, 1'b0);
      check("irq_set", o_irq, 1);
      axi_write("w_status_w1c", 8'h30, 32'h4, 4'hF, OK, 1'b0);
      check("irq_cleared", o_irq, 0);
      axi_read("r_status_after_w1c", 8'h30, 32'h1, OK);

      // Slave command capture, then strobe colliding with W1C of bit 1
      pulse_s(32'hC0DE_0001, 32'hDA7A_0001);
      axi_read("r_status_s_new", 8'h30, 32'h3, OK);
      i_s_sfp_cmd  = 32'hC0DE_0002;
      i_s_sfp_data = 32'hDA7A_0002;
      axi_write("w_status_vs_strobe", 8'h30, 32'h2, 4'hF, OK, 1'b1);
      axi_read("r_status_set_wins", 8'h30, 32'hB, OK);
      axi_read("r_s_cmd", 8'h28, 32'hC0DE_0002, OK);
      axi_read("r_s_data", 8'h2C, 32'hDA7A_0002, OK);

      // Slave response
      axi_write("w_s_rsp_lo", 8'h14, 32'h89AB_CDEF, 4'hF, OK, 1'b0);
      axi_write("w_s_rsp_hi", 8'h18, 32'h0123_4567, 4'hF, OK, 1'b0);
      check("s_rsp_before_go", o_s_sfp_rsp, 64'h0);
      axi_write("w_s_rsp_go", 8'h1C, 32'h1, 4'hF, OK, 1'b0);
      check("s_rsp_out", o_s_sfp_rsp, 64'h0123_4567_89AB_CDEF);
      check("s_flag_one_pulse", s_flag_cnt, 1);
      axi_read("r_s_rsp_go", 8'h1C, 32'h0, OK);

      // Station status window and freeze
      ch_status[35*32 +: 32] = 32'hDEAD_BEEF;
      ch_status[0 +: 32]     = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      axi_read("r_st3_w8", 8'hCC, 32'hDEAD_BEEF, OK);
      axi_read("r_st0_w0", 8'h40, 32'h1234_5678, OK);
      axi_write("w_freeze", 8'h00, 32'h3, 4'hF, OK, 1'b0);
      ch_status[35*32 +: 32] = 32'h0BAD_F00D;
      repeat (2) @(posedge clk);
      #1;
      axi_read("r_st_frozen", 8'hCC, 32'hDEAD_BEEF, OK);
      axi_write("w_unfreeze", 8'h00, 32'h1, 4'hF, OK, 1'b0);
      axi_read("r_st_live", 8'hCC, 32'h0BAD_F00D, OK);
      axi_read("r_st_oob", 8'hD0, 32'h0, ERR);

      // Error decoding
      axi_write("w_ro_m_rsp", 8'h20, 32'h1234_5678, 4'hF, ERR, 1'b0);
      axi_read("r_m_rsp_unchanged", 8'h20, 32'h7777_8888, OK);
      axi_write("w_ro_station", 8'hCC, 32'h0, 4'hF, ERR, 1'b0);
      axi_write("w_reserved", 8'h3C, 32'h0, 4'hF, ERR, 1'b0);
      axi_read("r_reserved", 8'h38, 32'h0, ERR);

      // Byte strobes
      axi_write("w_m_data_strb", 8'h0C, 32'hFFFF_FFFF, 4'b0010, OK, 1'b0);
      axi_read("r_m_data_strb", 8'h0C, 32'h0000_FF00, OK);
      check("m_data_out", o_m_sfp_data, 32'h0000_FF00);

      // B backpressure: second write presented while first B is held
      bq_name.push_back("hold_b1"); bq_resp.push_back(OK);
      bq_name.push_back("hold_b2"); bq_resp.push_back(OK);
      axi.bready  = 1'b0;
      axi.awaddr  = 8'h04;
      axi.wdata   = 32'h1;
      axi.wstrb   = 4'hF;
      axi.awvalid = 1'b1;
      axi.wvalid  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (axi.awready) ok = 1'b1;
      end
      check("hold_first_accept", ok, 1);
      @(posedge clk); #1;
      axi.wdata = 32'h2;
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid", axi.bvalid, 1);
         check("hold_no_awready", axi.awready, 0);
         @(posedge clk); #1;
      end
      check("hold_id_first", o_sfp_id, 1);
      axi.bready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (axi.awready) ok = 1'b1;
      end
      check("hold_second_accept", ok, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      for (int i = 0; i < 20 && !axi.bvalid; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("hold_id_second", o_sfp_id, 2);

      repeat (5) @(posedge clk);
      #1;
      check("queues_drained", bq_resp.size() + rq_data.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
